seq_bin_to_bcd: RTL and testbench
=================================

// Module: seq_bin_to_bcd
// PURPOSE
//  - Multi-cycle, parametrised binary-to-BCD converter (shift-and-add-3 / double-dabble).
//  - Converts one input bit per clock, so area stays flat as BIN_W grows.
//  - Sits between the score/cookie counter and the per-digit hex_decoder instances
//    driving HEX0..HEX(DIGITS-1).
//  - Adds a start/busy/done handshake and an overflow flag.
// PARAMETERS
//  BIN_W   31  width of the unsigned binary input, 1..32
//  DIGITS  10  number of BCD digits produced, 1..12; digit 0 = ones
// PORTS
//  clock        in   1          system clock; all state changes on the rising edge
//  resetn       in   1          synchronous, active-low reset
//  start        in   1          request a conversion; sampled only in IDLE or DONE
//  bin_in       in   BIN_W      unsigned value; captured on the edge that accepts start
//  busy         out  1          high while in SHIFT
//  done         out  1          one-cycle pulse; bcd_out/overflow are valid from this cycle
//  bcd_out      out  4*DIGITS   result; [3:0] = ones, [7:4] = tens, ...; held until the next done
//  overflow     out  1          result did not fit in DIGITS digits; updated with done
//  digit_blank  out  DIGITS     leading-zero mask; see CONFIGURATION
// BEHAVIOUR
//  - Reset (resetn=0 at a clock edge), from any state including mid-conversion:
//    - state=IDLE; busy=0, done=0, bcd_out=0, overflow=0, digit_blank=0.
//    - Scratch registers cleared. An aborted conversion never produces done.
//  - States: IDLE -> SHIFT -> DONE -> (IDLE | SHIFT).
//  - IDLE
//    - On start=1: capture bin_in into shift register sr, clear scratch digits and the
//      sticky overflow flag, load cnt=BIN_W, go to SHIFT.
//  - SHIFT, one bit per cycle:
//    - (a) Every scratch digit >=5 gets +3 (4-bit add, all digits in parallel).
//    - (b) Shift {digits, sr} left by 1: sr MSB enters ones[0]; each digit's bit 3 enters
//      the next digit's bit 0.
//    - (c) If bit 3 of the top digit after (a) is 1, set sticky overflow.
//    - (d) cnt decrements. When cnt reaches 1 at the edge, that edge performs the final
//      shift and goes to DONE.
//    - cnt width is $clog2(BIN_W+1).
//    - start is ignored in SHIFT; bin_in changes have no effect.
//  - DONE entry edge: bcd_out <= scratch digits, overflow <= sticky flag.
//    - done=1 for exactly this one cycle; busy=0.
//  - DONE
//    - If start=1: accept as in IDLE (back-to-back) and go to SHIFT.
//    - Otherwise go to IDLE.
//  - Latency: start accepted at edge k -> done high in the cycle after edge k+BIN_W.
//    Maximum throughput is one conversion per BIN_W+1 cycles.
//  - Overflow: bcd_out holds the low DIGITS decimal digits (value mod 10^DIGITS).
//    No saturation.
//  - bin_in=0 -> bcd_out=0, overflow=0.
//  - No invalid BCD digit (>9) may ever appear on bcd_out.
// CONFIGURATION
//  - Macro SEQ_BIN_TO_BCD_BLANK_EN.
//  - Defined: digit_blank is registered on the DONE entry edge.
//    - Bit i is 1 iff digit i and every higher digit are 0, for i>=1.
//    - Bit 0 is always 0, so a lone 0 is still shown.
//    - digit_blank=0 while overflow=1.
//    - Downstream forces blank segments (7'h7f) on masked digits.
//  - Not defined: digit_blank is tied to 0. No extra registers or logic.
// TESTING
//  - BIN_W=8, DIGITS=3: bin_in=255, start 1 cycle -> busy 8 cycles; done at cycle 9;
//    bcd_out=12'h255, overflow=0.
//  - Defaults: bin_in=31'h7FFFFFFF -> bcd_out=40'h2147483647, overflow=0, done 32 cycles
//    after accept.
//  - BIN_W=8, DIGITS=2: bin_in=100 -> bcd_out=8'h00, overflow=1; next bin_in=99 ->
//    8'h99, overflow=0.
//  - Handshake:
//    - start held high continuously -> conversions back-to-back, done every BIN_W+1 cycles.
//    - start pulsed while busy -> ignored; result matches the first value.
//  - Reset mid-op: resetn=0 at SHIFT cycle 4 -> next cycle IDLE, all outputs 0, no done;
//    a new conversion then gives a correct result.
//  - BLANK_EN, BIN_W=8, DIGITS=3:
//    - bin_in=42 -> digit_blank=3'b100.
//    - bin_in=0 -> 3'b110.
//    - bin_in=200 -> 3'b000.
//    - Without the macro -> always 3'b000.

Source files
------------

// File: rtl/seq_bin_to_bcd.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Optional leading-zero mask enabled by defining SEQ_BIN_TO_BCD_BLANK_EN.
module seq_bin_to_bcd #(
  parameter int BIN_W  = 31,
  parameter int DIGITS = 10
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [DIGITS-1:0]     digit_blank
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r;
  logic [BIN_W-1:0]   sr_r;
  logic [BCD_W-1:0]   dig_r;
  logic               ovf_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [BCD_W-1:0]   adj_s;
  logic [BCD_W-1:0]   dig_next_s;
  logic               ovf_next_s;
  logic               last_shift_s;

  // Add-3 correction of every scratch digit that would reach 10 or more when doubled
  always_comb begin
    adj_s = dig_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_r[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = dig_r[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = dig_r[4*i +: 4];
      end
    end
  end

  // The bit leaving the top digit is lost, which is exactly the overflow condition
  assign dig_next_s   = {adj_s[BCD_W-2:0], sr_r[BIN_W-1]};
  assign ovf_next_s   = ovf_r | adj_s[BCD_W-1];
  assign last_shift_s = (state_r == SHIFT) && (cnt_r == CNT_W'(1));

  // Conversion FSM with registered handshake and result outputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      sr_r     <= '0;
      dig_r    <= '0;
      ovf_r    <= 1'b0;
      cnt_r    <= '0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sr_r    <= bin_in;
            dig_r   <= '0;
            ovf_r   <= 1'b0;
            cnt_r   <= CNT_W'(BIN_W);
            busy    <= 1'b1;
            state_r <= SHIFT;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          sr_r  <= sr_r << 1'b1;
          dig_r <= dig_next_s;
          ovf_r <= ovf_next_s;
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_r  <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            bcd_out  <= dig_next_s;
            overflow <= ovf_next_s;
          end else begin
            state_r <= SHIFT;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_BIN_TO_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_r;
  logic [DIGITS-1:0] blank_next_s;
  logic              all_zero_s;

  // Mask digit i when it and every digit above it are zero; digit 0 is never masked
  always_comb begin
    blank_next_s = '0;
    all_zero_s   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero_s      = all_zero_s & (dig_next_s[4*i +: 4] == 4'd0);
      blank_next_s[i] = all_zero_s & ~ovf_next_s;
    end
  end

  // Leading-zero mask register, updated together with bcd_out
  always_ff @(posedge clock) begin
    if (!resetn) begin
      blank_r <= '0;
    end else if (last_shift_s) begin
      blank_r <= blank_next_s;
    end else begin
      blank_r <= blank_r;
    end
  end

  assign digit_blank = blank_r;
`else
  assign digit_blank = '0;
`endif

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Self-checking bench: three converter instances (8/3, 8/2, 31/10) against an arithmetic model.
module tb_seq_bin_to_bcd;

  logic        clock;
  logic        resetn;
  logic        start_ab;
  logic [7:0]  bin_ab;
  logic        start_c;
  logic [30:0] bin_c;

  logic        busy_a, done_a, ovf_a;
  logic [11:0] bcd_a;
  logic [2:0]  blank_a;
  logic        busy_b, done_b, ovf_b;
  logic [7:0]  bcd_b;
  logic [1:0]  blank_b;
  logic        busy_c, done_c, ovf_c;
  logic [39:0] bcd_c;
  logic [9:0]  blank_c;

  int errors = 0;
  int checks = 0;

  int                W_M [3] = '{8, 8, 31};
  int                D_M [3] = '{3, 2, 10};
  int                left_m [3];
  longint unsigned   val_m [3];
  logic              e_busy [3];
  logic              e_done [3];
  logic [47:0]       e_bcd [3];
  logic              e_ovf [3];
  logic [11:0]       e_blank [3];

  seq_bin_to_bcd #(.BIN_W(8), .DIGITS(3)) dut_a (
    .clock(clock), .resetn(resetn), .start(start_ab), .bin_in(bin_ab),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a), .digit_blank(blank_a));

  seq_bin_to_bcd #(.BIN_W(8), .DIGITS(2)) dut_b (
    .clock(clock), .resetn(resetn), .start(start_ab), .bin_in(bin_ab),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b), .digit_blank(blank_b));

  seq_bin_to_bcd dut_c (
    .clock(clock), .resetn(resetn), .start(start_c), .bin_in(bin_c),
    .busy(busy_c), .done(done_c), .bcd_out(bcd_c), .overflow(ovf_c), .digit_blank(blank_c));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [47:0] to_bcd(input longint unsigned v, input int d);
    logic [47:0] r = '0;
    longint unsigned x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [11:0] blank_of(input longint unsigned m, input int d, input logic ovf);
    logic [11:0] r = '0;
`ifdef SEQ_BIN_TO_BCD_BLANK_EN
    for (int i = 1; i < d; i++) r[i] = !ovf && (m < pow10(i));
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Outputs expected after the coming clock edge, from a countdown of remaining bits
  task automatic model_step(input int k, input logic rn, input logic st, input longint unsigned bin);
    longint unsigned p, m;
    if (!rn) begin
      left_m[k] = 0; e_busy[k] = 1'b0; e_done[k] = 1'b0;
      e_bcd[k] = '0; e_ovf[k] = 1'b0; e_blank[k] = '0;
    end else if (left_m[k] > 0) begin
      left_m[k]--;
      if (left_m[k] == 0) begin
        p = pow10(D_M[k]);
        m = val_m[k] % p;
        e_done[k]  = 1'b1;
        e_busy[k]  = 1'b0;
        e_ovf[k]   = (val_m[k] >= p);
        e_bcd[k]   = to_bcd(m, D_M[k]);
        e_blank[k] = blank_of(m, D_M[k], val_m[k] >= p);
      end else begin
        e_done[k] = 1'b0;
        e_busy[k] = 1'b1;
      end
    end else begin
      e_done[k] = 1'b0;
      if (st) begin
        val_m[k]  = bin;
        left_m[k] = W_M[k];
        e_busy[k] = 1'b1;
      end else begin
        e_busy[k] = 1'b0;
      end
    end
  endtask

  task automatic cmp(input int k, input logic b, input logic d, input logic [47:0] bcd,
                     input logic o, input logic [11:0] bl);
    chk($sformatf("busy[%0d]", k), 64'(b), 64'(e_busy[k]));
    chk($sformatf("done[%0d]", k), 64'(d), 64'(e_done[k]));
    chk($sformatf("bcd[%0d]", k), 64'(bcd), 64'(e_bcd[k]));
    chk($sformatf("overflow[%0d]", k), 64'(o), 64'(e_ovf[k]));
    chk($sformatf("blank[%0d]", k), 64'(bl), 64'(e_blank[k]));
  endtask

  // Per-cycle comparison of every instance against the model
  always @(negedge clock) begin
    cmp(0, busy_a, done_a, 48'(bcd_a), ovf_a, 12'(blank_a));
    cmp(1, busy_b, done_b, 48'(bcd_b), ovf_b, 12'(blank_b));
    cmp(2, busy_c, done_c, 48'(bcd_c), ovf_c, 12'(blank_c));
  end

  task automatic cyc(input logic rn, input logic sab, input logic [7:0] bab,
                     input logic sc, input logic [30:0] bc);
    resetn = rn; start_ab = sab; bin_ab = bab; start_c = sc; bin_c = bc;
    model_step(0, rn, sab, 64'(bab));
    model_step(1, rn, sab, 64'(bab));
    model_step(2, rn, sc, 64'(bc));
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'd0, 1'b0, 31'd0);
  endtask

  task automatic conv_ab(input logic [7:0] v);
    cyc(1'b1, 1'b1, v, 1'b0, 31'd0);
    idle(8);
  endtask

  logic [2:0] exp_bl42, exp_bl0, exp_bl200;

  initial begin
`ifdef SEQ_BIN_TO_BCD_BLANK_EN
    exp_bl42 = 3'b100; exp_bl0 = 3'b110; exp_bl200 = 3'b000;
`else
    exp_bl42 = 3'b000; exp_bl0 = 3'b000; exp_bl200 = 3'b000;
`endif
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'd0, 1'b0, 31'd0);
    chk("reset_bcd_c", 64'(bcd_c), 64'd0);

    cyc(1'b1, 1'b1, 8'd255, 1'b1, 31'h7FFFFFFF);
    idle(8);
    chk("pin_done_255", 64'(done_a), 64'd1);
    chk("pin_bcd_255", 64'(bcd_a), 64'h255);
    chk("pin_ovf_255", 64'(ovf_a), 64'd0);
    chk("pin_bcd_255_d2", 64'(bcd_b), 64'h55);
    chk("pin_ovf_255_d2", 64'(ovf_b), 64'd1);
    idle(23);
    chk("pin_done_max", 64'(done_c), 64'd1);
    chk("pin_bcd_max", 64'(bcd_c), 64'h2147483647);
    chk("pin_ovf_max", 64'(ovf_c), 64'd0);

    conv_ab(8'd100);
    chk("pin_bcd_100_d2", 64'(bcd_b), 64'h00);
    chk("pin_ovf_100_d2", 64'(ovf_b), 64'd1);
    chk("pin_bcd_100", 64'(bcd_a), 64'h100);
    conv_ab(8'd99);
    chk("pin_bcd_99_d2", 64'(bcd_b), 64'h99);
    chk("pin_ovf_99_d2", 64'(ovf_b), 64'd0);

    conv_ab(8'd42);
    chk("pin_blank_42", 64'(blank_a), 64'(exp_bl42));
    conv_ab(8'd0);
    chk("pin_bcd_0", 64'(bcd_a), 64'h0);
    chk("pin_blank_0", 64'(blank_a), 64'(exp_bl0));
    conv_ab(8'd200);
    chk("pin_blank_200", 64'(blank_a), 64'(exp_bl200));

    // start held high: back-to-back conversions
    for (int i = 0; i < 27; i++) cyc(1'b1, 1'b1, 8'(i * 9 + 17), 1'b0, 31'd0);
    idle(10);

    // start pulsed while busy is ignored
    cyc(1'b1, 1'b1, 8'd77, 1'b0, 31'd0);
    idle(2);
    cyc(1'b1, 1'b1, 8'd200, 1'b0, 31'd0);
    idle(5);
    chk("pin_done_77", 64'(done_a), 64'd1);
    chk("pin_bcd_77", 64'(bcd_a), 64'h077);

    // reset in the middle of a conversion
    cyc(1'b1, 1'b1, 8'd123, 1'b0, 31'd0);
    idle(3);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 31'd0);
    chk("pin_abort_busy", 64'(busy_a), 64'd0);
    chk("pin_abort_bcd", 64'(bcd_a), 64'd0);
    idle(10);
    conv_ab(8'd58);
    chk("pin_bcd_58", 64'(bcd_a), 64'h058);

    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) == 0), 8'($urandom),
          ($urandom_range(0, 2) == 0), 31'($urandom));
    end
    idle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
